// File: rtl/ram16_arbiter.sv
// Round-robin arbiter sharing one ram16 (16x1, registered read) between two requesters.
// Define RAM16_ARB_CLEAR_EN to clear all 16 locations to CLEAR_VAL after reset release.
module ram16_arbiter #(
    parameter logic CLEAR_VAL = 1'b0,
    parameter logic RR_INIT   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_write,
    input  logic [7:0] req_addr,
    input  logic [1:0] req_wdata,
    output logic [1:0] req_ready,
    output logic [1:0] rsp_valid,
    output logic       rsp_data,
    output logic       mem_write_enable,
    output logic       mem_set,
    output logic [3:0] mem_address,
    input  logic       mem_result
);

    // Handshake: a command i transfers on a rising edge where req_valid[i] && req_ready[i];
    // requesters hold valid/write/addr/wdata stable until then. Responses are one-cycle
    // strobes on rsp_valid[i], two cycles after the accepting edge, in acceptance order.

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

`ifdef RAM16_ARB_CLEAR_EN
    localparam state_t ST_RESET = ST_CLEAR;
`else
    localparam state_t ST_RESET = ST_RUN;
`endif

    state_t     state, state_nxt;
    logic [3:0] clr_cnt;
    logic       last_grant;
    logic       grant_id;
    logic       accept;
    logic       p1_valid;
    logic       p1_id;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RESET;
            clr_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 4'd1;
            end
        end
    end

    // Next state: the clear sequence ends once address 15 has been issued
    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_cnt == 4'hF) begin
            state_nxt = ST_RUN;
        end
    end

    // Outputs: grant selection and ready; gated by rst_n so ready drops asynchronously
    always_comb begin
        grant_id = 1'b0;
        if (req_valid == 2'b11) begin
            grant_id = ~last_grant;
        end else if (req_valid[1]) begin
            grant_id = 1'b1;
        end
        req_ready = 2'b00;
        if (rst_n && state == ST_RUN) begin
            req_ready[grant_id] = req_valid[grant_id];
        end
    end

    assign accept   = |req_ready;
    assign rsp_data = (|rsp_valid) & mem_result;

    // Command registers and the two-stage response pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant       <= RR_INIT;
            mem_write_enable <= 1'b0;
            mem_set          <= 1'b0;
            mem_address      <= 4'd0;
            p1_valid         <= 1'b0;
            p1_id            <= 1'b0;
            rsp_valid        <= 2'b00;
        end else begin
            p1_valid  <= accept;
            p1_id     <= grant_id;
            rsp_valid <= p1_valid ? (p1_id ? 2'b10 : 2'b01) : 2'b00;
            if (state == ST_CLEAR) begin
                mem_write_enable <= 1'b1;
                mem_address      <= clr_cnt;
                mem_set          <= CLEAR_VAL;
            end else if (accept) begin
                last_grant       <= grant_id;
                mem_write_enable <= req_write[grant_id];
                mem_address      <= req_addr[{grant_id, 2'b00} +: 4];
                mem_set          <= req_wdata[grant_id];
            end else begin
                mem_write_enable <= 1'b0;
            end
        end
    end

endmodule
